// File: rtl/coil_step_decoder_if.sv
// Coil-bus decoder connection: coil pattern and control pulses in, step
// events and odometry/status out.
interface coil_step_decoder_if #(
  parameter int POS_W = 16
);
  logic [3:0]       coil;
  logic             pos_clr;
  logic             fault_clr;
  logic             step_pulse;
  logic             step_dir;
  logic [POS_W-1:0] position;
  logic [1:0]       phase;
  logic             locked;
  logic             fault;
  logic             stalled;

  modport master (
    output coil, pos_clr, fault_clr,
    input  step_pulse, step_dir, position, phase, locked, fault, stalled
  );

  modport slave (
    input  coil, pos_clr, fault_clr,
    output step_pulse, step_dir, position, phase, locked, fault, stalled
  );
endinterface

// File: rtl/coil_step_decoder.sv
// Wave-drive stepper coil decoder: synchronizes and debounces the coil
// pattern, tracks phase/direction, keeps a signed odometer and drive faults.
module coil_step_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int STALL_CYCLES  = 1000000
) (
  input logic                clk,
  input logic                rst,
  coil_step_decoder_if.slave bus
);

  localparam int CNT_W   = 9;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  logic [3:0]       sync1_q, csync_q, prev_q;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             accept;

  state_e           state_q, state_d;
  logic [1:0]       phase_q;
  logic [POS_W-1:0] position_q;
  logic             step_pulse_q, step_dir_q;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic             is_onehot;
  logic [1:0]       p_idx;
  logic [1:0]       delta;
  logic             step_fwd, step_rev, phase_load;

  // Synchronizer plus one more stage so a change in csync can be detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'b0000;
      csync_q    <= 4'b0000;
      prev_q     <= 4'b0000;
      filt_cnt_q <= '0;
    end else begin
      sync1_q    <= bus.coil;
      csync_q    <= sync1_q;
      prev_q     <= csync_q;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Counter stops one past the threshold so each stable run is accepted once.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (csync_q != prev_q) begin
      filt_cnt_d = CNT_W'(1);
    end else if (filt_cnt_q <= CNT_W'(FILTER_CYCLES)) begin
      filt_cnt_d = filt_cnt_q + CNT_W'(1);
    end
  end

  assign accept = (csync_q == prev_q) && (filt_cnt_q == CNT_W'(FILTER_CYCLES));

  always_comb begin
    is_onehot = 1'b1;
    p_idx     = 2'd0;
    case (csync_q)
      4'b0001: p_idx = 2'd0;
      4'b0010: p_idx = 2'd1;
      4'b0100: p_idx = 2'd2;
      4'b1000: p_idx = 2'd3;
      default: is_onehot = 1'b0;
    endcase
  end

  assign delta = p_idx - phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (accept) begin
          if (is_onehot) begin
            state_d = ST_LOCKED;
          end else if (csync_q != 4'b0000) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          if (csync_q == 4'b0000) begin
            state_d = ST_UNLOCKED;
          end else if (!is_onehot || delta == 2'd2) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    step_fwd   = 1'b0;
    step_rev   = 1'b0;
    phase_load = 1'b0;
    case (state_q)
      ST_UNLOCKED: phase_load = accept && is_onehot;
      ST_LOCKED: begin
        step_fwd = accept && is_onehot && (delta == 2'd1);
        step_rev = accept && is_onehot && (delta == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      phase_q      <= 2'd0;
      position_q   <= '0;
      stall_q      <= '0;
    end else begin
      step_pulse_q <= step_fwd || step_rev;
      stall_q      <= stall_d;
      if (step_fwd || step_rev) begin
        step_dir_q <= step_fwd;
      end
      if (step_fwd || step_rev || phase_load) begin
        phase_q <= p_idx;
      end
      // A coincident clear wins over the step count.
      if (bus.pos_clr) begin
        position_q <= '0;
      end else if (step_fwd) begin
        position_q <= position_q + POS_W'(1);
      end else if (step_rev) begin
        position_q <= position_q - POS_W'(1);
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (state_d != ST_LOCKED || state_q != ST_LOCKED || step_fwd || step_rev) begin
      stall_d = '0;
    end else if (stall_q != STALL_W'(STALL_CYCLES)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign bus.step_pulse = step_pulse_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.position   = position_q;
  assign bus.phase      = phase_q;
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.stalled    = (stall_q == STALL_W'(STALL_CYCLES));

endmodule
